// File: rtl/req_initiator.sv
// Requester side of a level-req / pulse-ack handshake with timeout, bounded retry,
// minimum low gap and latency report. Optional counters: define REQ_INIT_STATS_EN.
module req_initiator #(
    parameter int unsigned DW        = 8,
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned LOW_GAP   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] start_data,
    input  logic          ack,
    output logic          req,
    output logic [DW-1:0] req_data,
    output logic          busy,
    output logic          done,
    output logic          err,
`ifdef REQ_INIT_STATS_EN
    output logic [15:0]   done_cnt,
    output logic [15:0]   err_cnt,
    output logic [15:0]   retry_cnt,
`endif
    output logic [7:0]    latency
);

    localparam int unsigned CW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned GW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  wait_cnt, wait_nxt;
    logic [AW-1:0]  attempt_cnt, attempt_nxt;
    logic [GW-1:0]  gap_cnt, gap_nxt;
    logic           final_flag, final_nxt;
    logic           req_nxt, busy_nxt, done_nxt, err_nxt;
    logic [DW-1:0]  req_data_nxt;
    logic [7:0]     latency_nxt;

    logic accept, ack_hit, timeout_hit, last_attempt, gap_end;

    // Event decode; ack takes priority over a coincident timeout.
    always_comb begin
        accept       = (state == IDLE) && start;
        ack_hit      = (state == REQ) && ack;
        timeout_hit  = (state == REQ) && !ack && (wait_cnt == CW'(TIMEOUT - 1));
        last_attempt = (attempt_cnt == AW'(MAX_RETRY));
        gap_end      = (state == GAP) && (gap_cnt == GW'(LOW_GAP - 1));
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            attempt_cnt <= '0;
            gap_cnt     <= '0;
            final_flag  <= 1'b0;
            req         <= 1'b0;
            req_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            latency     <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            attempt_cnt <= attempt_nxt;
            gap_cnt     <= gap_nxt;
            final_flag  <= final_nxt;
            req         <= req_nxt;
            req_data    <= req_data_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
            latency     <= latency_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = REQ;
            REQ:     if (ack_hit || timeout_hit) state_nxt = GAP;
            GAP:     if (gap_end) state_nxt = final_flag ? IDLE : REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for outputs and counters.
    always_comb begin
        wait_nxt     = wait_cnt;
        attempt_nxt  = attempt_cnt;
        gap_nxt      = gap_cnt;
        final_nxt    = final_flag;
        req_nxt      = req;
        req_data_nxt = req_data;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        latency_nxt  = latency;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_data_nxt = start_data;
                    busy_nxt     = 1'b1;
                    req_nxt      = 1'b1;
                    attempt_nxt  = '0;
                    wait_nxt     = '0;
                end
            end
            REQ: begin
                wait_nxt = wait_cnt + CW'(1);
                if (ack_hit) begin
                    req_nxt     = 1'b0;
                    done_nxt    = 1'b1;
                    latency_nxt = wait_cnt + CW'(1);
                    final_nxt   = 1'b1;
                    gap_nxt     = '0;
                    wait_nxt    = '0;
                end else if (timeout_hit) begin
                    req_nxt  = 1'b0;
                    gap_nxt  = '0;
                    wait_nxt = '0;
                    if (last_attempt) begin
                        err_nxt   = 1'b1;
                        final_nxt = 1'b1;
                    end else begin
                        attempt_nxt = attempt_cnt + AW'(1);
                        final_nxt   = 1'b0;
                    end
                end
            end
            GAP: begin
                gap_nxt = gap_cnt + GW'(1);
                if (gap_end) begin
                    gap_nxt = '0;
                    if (final_flag) begin
                        busy_nxt  = 1'b0;
                        final_nxt = 1'b0;
                    end else begin
                        req_nxt  = 1'b1;
                        wait_nxt = '0;
                    end
                end
            end
            default: begin
                req_nxt  = 1'b0;
                busy_nxt = 1'b0;
            end
        endcase
    end

`ifdef REQ_INIT_STATS_EN
    // Event counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt  <= '0;
            err_cnt   <= '0;
            retry_cnt <= '0;
        end else begin
            if (ack_hit)                       done_cnt  <= done_cnt + 16'd1;
            if (timeout_hit && last_attempt)   err_cnt   <= err_cnt + 16'd1;
            if (timeout_hit && !last_attempt)  retry_cnt <= retry_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_req_initiator.sv
// Self-checking bench for req_initiator: vector table plus hand-written
// timeout/retry/reset sequences; second instance covers MAX_RETRY=0, LOW_GAP=1.
module tb_req_initiator;

    logic       clk = 1'b0;
    logic       rst, start, ack;
    logic [7:0] start_data;
    logic       req, busy, done, err;
    logic [7:0] req_data, latency;

    logic       start0, ack0;
    logic [7:0] start_data0;
    logic       req0, busy0, done0, err0;
    logic [7:0] req_data0, latency0;

`ifdef REQ_INIT_STATS_EN
    logic [15:0] done_cnt, err_cnt, retry_cnt;
    logic [15:0] done_cnt0, err_cnt0, retry_cnt0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    req_initiator dut (
        .clk(clk), .rst(rst), .start(start), .start_data(start_data), .ack(ack),
        .req(req), .req_data(req_data), .busy(busy), .done(done), .err(err),
`ifdef REQ_INIT_STATS_EN
        .done_cnt(done_cnt), .err_cnt(err_cnt), .retry_cnt(retry_cnt),
`endif
        .latency(latency)
    );

    req_initiator #(.DW(8), .TIMEOUT(4), .MAX_RETRY(0), .LOW_GAP(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .start_data(start_data0), .ack(ack0),
        .req(req0), .req_data(req_data0), .busy(busy0), .done(done0), .err(err0),
`ifdef REQ_INIT_STATS_EN
        .done_cnt(done_cnt0), .err_cnt(err_cnt0), .retry_cnt(retry_cnt0),
`endif
        .latency(latency0)
    );

    typedef struct {
        bit       rst;
        bit       start;
        bit [7:0] sdata;
        bit       ack;
        bit       req;
        bit       busy;
        bit       done;
        bit       err;
        bit [7:0] lat;
        bit [7:0] rdata;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit [7:0] d, input bit a);
        rst = r; start = s; start_data = d; ack = a;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; ack = 1'b0;
    endtask

    task automatic expect_o(input string tag, input bit e_req, input bit e_busy,
                            input bit e_done, input bit e_err,
                            input bit [7:0] e_lat, input bit [7:0] e_data);
        check({tag, ".req"},      int'(req),      int'(e_req));
        check({tag, ".busy"},     int'(busy),     int'(e_busy));
        check({tag, ".done"},     int'(done),     int'(e_done));
        check({tag, ".err"},      int'(err),      int'(e_err));
        check({tag, ".latency"},  int'(latency),  int'(e_lat));
        check({tag, ".req_data"}, int'(req_data), int'(e_data));
    endtask

    function automatic vec_t mk(bit r, bit s, bit [7:0] d, bit a, bit q, bit b,
                                bit dn, bit e, bit [7:0] l, bit [7:0] rd);
        vec_t v;
        v.rst = r; v.start = s; v.sdata = d; v.ack = a;
        v.req = q; v.busy = b; v.done = dn; v.err = e; v.lat = l; v.rdata = rd;
        return v;
    endfunction

    // Runs one full timed-out attempt plus its gap; retry re-raises req at gap end.
    task automatic timeout_attempt(input string tag, input bit last,
                                   input bit [7:0] lat, input bit [7:0] data);
        for (int c = 1; c <= 15; c++) begin
            step(0, 0, 8'h00, 0);
            expect_o($sformatf("%s.c%0d", tag, c), c < 15, 1'b1, 1'b0,
                     (c == 15) && last, lat, data);
        end
        step(0, 0, 8'h00, 0);
        expect_o({tag, ".gap1"}, 1'b0, 1'b1, 1'b0, 1'b0, lat, data);
        step(0, 0, 8'h00, 0);
        expect_o({tag, ".gap2"}, !last, !last, 1'b0, 1'b0, lat, data);
    endtask

    vec_t vecs[12];

    initial begin
        rst = 1'b1; start = 1'b0; ack = 1'b0; start_data = 8'h00;
        start0 = 1'b0; ack0 = 1'b0; start_data0 = 8'h00;

        // Reset, first request with ack in 6th cycle, stray starts/acks, new start.
        vecs[0]  = mk(1, 0, 8'h00, 0,  0, 0, 0, 0, 8'd0, 8'h00);
        vecs[1]  = mk(0, 1, 8'hA5, 0,  1, 1, 0, 0, 8'd0, 8'hA5);
        vecs[2]  = mk(0, 0, 8'h00, 0,  1, 1, 0, 0, 8'd0, 8'hA5);
        vecs[3]  = mk(0, 1, 8'h3C, 0,  1, 1, 0, 0, 8'd0, 8'hA5);
        vecs[4]  = mk(0, 0, 8'h00, 0,  1, 1, 0, 0, 8'd0, 8'hA5);
        vecs[5]  = mk(0, 0, 8'h00, 0,  1, 1, 0, 0, 8'd0, 8'hA5);
        vecs[6]  = mk(0, 0, 8'h00, 0,  1, 1, 0, 0, 8'd0, 8'hA5);
        vecs[7]  = mk(0, 0, 8'h00, 1,  0, 1, 1, 0, 8'd6, 8'hA5);
        vecs[8]  = mk(0, 1, 8'h3C, 0,  0, 1, 0, 0, 8'd6, 8'hA5);
        vecs[9]  = mk(0, 1, 8'h3C, 1,  0, 0, 0, 0, 8'd6, 8'hA5);
        vecs[10] = mk(0, 0, 8'h00, 1,  0, 0, 0, 0, 8'd6, 8'hA5);
        vecs[11] = mk(0, 1, 8'h5A, 0,  1, 1, 0, 0, 8'd6, 8'h5A);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].sdata, vecs[i].ack);
            expect_o($sformatf("vec%0d", i), vecs[i].req, vecs[i].busy,
                     vecs[i].done, vecs[i].err, vecs[i].lat, vecs[i].rdata);
        end

        // ack on the timeout edge: done wins, no retry.
        for (int c = 1; c <= 14; c++) begin
            step(0, 0, 8'h00, 0);
            expect_o($sformatf("edge.c%0d", c), 1'b1, 1'b1, 1'b0, 1'b0, 8'd6, 8'h5A);
        end
        step(0, 0, 8'h00, 1);
        expect_o("edge.ack", 1'b0, 1'b1, 1'b1, 1'b0, 8'd15, 8'h5A);
        step(0, 0, 8'h00, 0);
        expect_o("edge.gap1", 1'b0, 1'b1, 1'b0, 1'b0, 8'd15, 8'h5A);
        step(0, 0, 8'h00, 0);
        expect_o("edge.gap2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd15, 8'h5A);
        step(0, 0, 8'h00, 0);
        expect_o("edge.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd15, 8'h5A);

        // No ack: four attempts then err; latency untouched.
        step(0, 1, 8'h77, 0);
        expect_o("to.start", 1'b1, 1'b1, 1'b0, 1'b0, 8'd15, 8'h77);
        for (int a = 0; a < 4; a++)
            timeout_attempt($sformatf("to.a%0d", a), a == 3, 8'd15, 8'h77);
`ifdef REQ_INIT_STATS_EN
        check("stats.err_cnt", int'(err_cnt), 1);
        check("stats.retry_cnt", int'(retry_cnt), 3);
        check("stats.done_cnt", int'(done_cnt), 2);
`endif

        // Two timeouts then ack in 3rd cycle of attempt 3.
        step(0, 1, 8'h11, 0);
        expect_o("rt.start", 1'b1, 1'b1, 1'b0, 1'b0, 8'd15, 8'h11);
        timeout_attempt("rt.a0", 1'b0, 8'd15, 8'h11);
        timeout_attempt("rt.a1", 1'b0, 8'd15, 8'h11);
        step(0, 0, 8'h00, 0);
        expect_o("rt.c1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd15, 8'h11);
        step(0, 0, 8'h00, 0);
        expect_o("rt.c2", 1'b1, 1'b1, 1'b0, 1'b0, 8'd15, 8'h11);
        step(0, 0, 8'h00, 1);
        expect_o("rt.ack", 1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 8'h11);
`ifdef REQ_INIT_STATS_EN
        check("stats.retry_cnt2", int'(retry_cnt), 5);
        check("stats.done_cnt2", int'(done_cnt), 3);
        check("stats.err_cnt2", int'(err_cnt), 1);
`endif
        step(0, 0, 8'h00, 0);
        expect_o("rt.gap1", 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'h11);
        step(0, 0, 8'h00, 0);
        expect_o("rt.gap2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'h11);

        // Reset in the 4th REQ cycle aborts silently.
        step(0, 1, 8'h22, 0);
        expect_o("rs.start", 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 8'h22);
        for (int c = 1; c <= 3; c++) begin
            step(0, 0, 8'h00, 0);
            expect_o($sformatf("rs.c%0d", c), 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 8'h22);
        end
        step(1, 0, 8'h00, 0);
        expect_o("rs.rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
        step(0, 0, 8'h00, 1);
        expect_o("rs.stray", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
        step(0, 1, 8'h33, 0);
        expect_o("rs.restart", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'h33);
        step(0, 0, 8'h00, 1);
        expect_o("rs.ack", 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'h33);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        expect_o("rs.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'h33);

        // MAX_RETRY=0, TIMEOUT=4, LOW_GAP=1 instance: err after first attempt.
        start0 = 1'b1; start_data0 = 8'h99;
        @(posedge clk); #1;
        start0 = 1'b0;
        check("nr.req", int'(req0), 1);
        check("nr.busy", int'(busy0), 1);
        check("nr.data", int'(req_data0), 32'h99);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("nr.c%0d.req", c), int'(req0), 1);
            check($sformatf("nr.c%0d.err", c), int'(err0), 0);
        end
        @(posedge clk); #1;
        check("nr.to.req", int'(req0), 0);
        check("nr.to.err", int'(err0), 1);
        check("nr.to.busy", int'(busy0), 1);
        check("nr.to.done", int'(done0), 0);
        @(posedge clk); #1;
        check("nr.gap.busy", int'(busy0), 0);
        check("nr.gap.err", int'(err0), 0);
        check("nr.gap.req", int'(req0), 0);
        @(posedge clk); #1;
        check("nr.idle.req", int'(req0), 0);
        check("nr.idle.lat", int'(latency0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
